hera_ram_arb: RTL

- Arbitrates the single-port data RAM (hera_ram) between two requesters: the CPU datapath (alu_top memory ops) and a debug/visualizer master (vis_dev host-side memory peek/poke).
- CPU has fixed priority. The debug master is protected from starvation by an age counter: after STARVE_LIMIT blocked cycles, it is forced through and the CPU is stalled for one cycle.
- Sits between alu_top/vis_dev and hera_ram in the hera top level. cpu_stall feeds the decoder hold_pc path.

---
 rtl/hera_ram_arb_pkg.sv | 27 ++
 rtl/hera_ram_arb_if.sv | 37 +++
 rtl/hera_ram_arb_starve_cnt.sv | 40 ++++
 rtl/hera_ram_arb.sv | 135 +++++++++++++
 4 files changed

// File: rtl/hera_ram_arb_pkg.sv
// Shared types and defaults for the hera data-RAM arbiter.
// Arbiter states, read-return ownership and a grant-decode helper.
package hera_ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF       = 11;
  localparam int unsigned DATA_W_DEF       = 16;
  localparam int unsigned STARVE_LIMIT_DEF = 8;
  localparam int unsigned STARVE_CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CPU   = 2'd1,
    ST_DBG   = 2'd2,
    ST_FORCE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } rd_owner_e;

  function automatic logic is_dbg_grant(input arb_state_e s);
    return (s == ST_DBG) || (s == ST_FORCE);
  endfunction

endpackage

// File: rtl/hera_ram_arb_if.sv
// Requester-side bus of the hera RAM arbiter: CPU port and debug port.
// slave = arbiter view, master = requester view.
interface hera_ram_arb_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rvalid, dbg_rdata, dbg_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rvalid, dbg_rdata, dbg_err
  );
endinterface

// File: rtl/hera_ram_arb_starve_cnt.sv
// Saturating debug-starvation counter with clear and limit-reached flag.
module hera_ram_arb_starve_cnt
  import hera_ram_arb_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/hera_ram_arb.sv
// Single-port data-RAM arbiter: CPU fixed priority, debug master with starvation guard.
// Optional HERA_ARB_WR_PROTECT_EN blocks debug writes at/above PROT_BASE.
module hera_ram_arb
  import hera_ram_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W       = ADDR_W_DEF,
  parameter int unsigned       DATA_W       = DATA_W_DEF,
  parameter int unsigned       STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter logic [ADDR_W-1:0] PROT_BASE    = 11'h700
) (
  input  logic              clk,
  input  logic              rst,
  hera_ram_arb_if.slave     bus,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_wren_o,
  input  logic [DATA_W-1:0] ram_q_i
);

  arb_state_e        state_q, state_d;
  rd_owner_e         rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] last_data_q;
  logic [DATA_W-1:0] cpu_hold_q;
  logic [DATA_W-1:0] dbg_hold_q;

  logic              at_limit_s;
  logic              force_s;
  logic              grant_dbg_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              sel_we_s;
  logic              prot_hit_s;

  hera_ram_arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (bus.dbg_req & ~grant_dbg_s),
    .clr_i     (~bus.dbg_req | grant_dbg_s),
    .at_limit_o(at_limit_s)
  );

  // Never let debug win two cycles running while the CPU is waiting.
  always_comb begin
    force_s = at_limit_s & bus.dbg_req & ~(bus.cpu_req & is_dbg_grant(state_q));
    if (rst) begin
      state_d = ST_IDLE;
    end else if (force_s) begin
      state_d = ST_FORCE;
    end else if (bus.cpu_req) begin
      state_d = ST_CPU;
    end else if (bus.dbg_req) begin
      state_d = ST_DBG;
    end else begin
      state_d = ST_IDLE;
    end
  end

  assign grant_dbg_s = is_dbg_grant(state_d);

  always_comb begin
    sel_addr_s = last_addr_q;
    sel_data_s = last_data_q;
    sel_we_s   = 1'b0;
    rd_owner_d = OWN_NONE;
    case (state_d)
      ST_CPU: begin
        sel_addr_s = bus.cpu_addr;
        sel_data_s = bus.cpu_wdata;
        sel_we_s   = bus.cpu_we;
        rd_owner_d = bus.cpu_we ? OWN_NONE : OWN_CPU;
      end
      ST_DBG, ST_FORCE: begin
        sel_addr_s = bus.dbg_addr;
        sel_data_s = bus.dbg_wdata;
        sel_we_s   = bus.dbg_we;
        rd_owner_d = bus.dbg_we ? OWN_NONE : OWN_DBG;
      end
      default: begin
        sel_addr_s = last_addr_q;
        sel_data_s = last_data_q;
        sel_we_s   = 1'b0;
        rd_owner_d = OWN_NONE;
      end
    endcase
  end

`ifdef HERA_ARB_WR_PROTECT_EN
  assign prot_hit_s = grant_dbg_s & bus.dbg_we & (bus.dbg_addr >= PROT_BASE);
`else
  logic unused_prot_s;
  assign unused_prot_s = ^PROT_BASE;
  assign prot_hit_s    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_owner_q  <= OWN_NONE;
      last_addr_q <= '0;
      last_data_q <= '0;
      cpu_hold_q  <= '0;
      dbg_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      if (state_d != ST_IDLE) begin
        last_addr_q <= sel_addr_s;
        last_data_q <= sel_data_s;
      end
      if (rd_owner_q == OWN_CPU) begin
        cpu_hold_q <= ram_q_i;
      end
      if (rd_owner_q == OWN_DBG) begin
        dbg_hold_q <= ram_q_i;
      end
    end
  end

  assign ram_addr_o = sel_addr_s;
  assign ram_data_o = sel_data_s;
  assign ram_wren_o = sel_we_s & ~prot_hit_s;

  assign bus.cpu_stall  = bus.cpu_req & grant_dbg_s;
  assign bus.dbg_ack    = grant_dbg_s;
  assign bus.dbg_err    = prot_hit_s;
  // The owner sees RAM output live; the other side keeps its last captured word.
  assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
  assign bus.dbg_rvalid = (rd_owner_q == OWN_DBG);
  assign bus.cpu_rdata  = (rd_owner_q == OWN_CPU) ? ram_q_i : cpu_hold_q;
  assign bus.dbg_rdata  = (rd_owner_q == OWN_DBG) ? ram_q_i : dbg_hold_q;

endmodule
